shift_add_mult: RTL



---
 rtl/shift_add_mult.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential unsigned shift-and-add multiplier.
// The operands are latched on an accepted start. The block then runs one
// iteration per multiplier bit. Each iteration conditionally adds the
// multiplicand into the high accumulator through the rca ripple adder, and
// shifts the {carry, accumulator, multiplier} chain right by one.
// The result appears on product together with a one-cycle done pulse.
// WIDTH must stay at 4, because it has to match the rca adder width.

// rca: 4-bit ripple carry adder used as the partial-product adder.
module rca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  // One full adder per bit; each carry ripples into the next stage.
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[4];

endmodule

module shift_add_mult #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     sum;
  logic                 cout;
  logic [2*WIDTH-1:0]   shifted;

  rca u_rca (
    .a    (acc_q),
    .b    (mcand_q),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // One iteration: add the multiplicand if the current multiplier LSB is set,
  // then shift the whole chain right. The adder carry becomes the new MSB.
  always_comb begin
    if (q_q[0]) begin
      shifted = {cout, sum, q_q[WIDTH-1:1]};
    end else begin
      shifted = {1'b0, acc_q, q_q[WIDTH-1:1]};
    end
  end

  // Next-state and next-output logic for the IDLE -> CALC -> DONE sequence.
  always_comb begin
    // NOTE: every target gets a default first so that no path leaves it unassigned (no latch).
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          q_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end

      CALC: begin
        {acc_d, q_d} = shifted;
        cnt_d        = cnt_q + 3'd1;
        if (cnt_q == 3'(WIDTH - 1)) begin
          product_d = shifted;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; asynchronous reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample its pre-edge inputs together.
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
